// File: rtl/vend_controller.sv
// Vending sequencer: select, dispense, greedy change return, counter clear.
// Optional cancel/refund path enabled by defining VEND_CANCEL_EN.
module vend_controller #(
  parameter int CREDIT_W        = 10,
  parameter int PRICE_A         = 65,
  parameter int PRICE_B         = 85,
  parameter int DISPENSE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CREDIT_W-1:0] inCredit,
  input  logic                inSelA,
  input  logic                inSelB,
`ifdef VEND_CANCEL_EN
  input  logic                inCancel,
`endif
  output logic                outDispenseA,
  output logic                outDispenseB,
  output logic                outRetQuarter,
  output logic                outRetDime,
  output logic                outRetNickel,
  output logic                outResetCount,
  output logic                outInsufficient,
  output logic                outCoinEnable
);

  if (PRICE_A > 2**CREDIT_W - 1 || PRICE_B > 2**CREDIT_W - 1)
  begin : g_price_chk
    $error("vend_controller: price exceeds credit range");
  end

  if (DISPENSE_CYCLES < 1 || DISPENSE_CYCLES > 15)
  begin : g_disp_chk
    $error("vend_controller: DISPENSE_CYCLES out of 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    CHANGE,
    CLEAR
  } state_t;

  localparam logic [CREDIT_W-1:0] PA  = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB  = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W-1:0] C25 = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] C10 = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] C5  = CREDIT_W'(5);
  localparam logic [3:0] CNT0 = 4'(DISPENSE_CYCLES - 1);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] rem, rem_n;
  logic [CREDIT_W-1:0] price;
  logic [3:0]          cnt, cnt_n;
  logic                sel_b, sel_b_n;
  logic                quarter_n, dime_n, nickel_n;
  logic                insuff_n;

  assign price = inSelA ? PA : PB;

  always_comb begin
    state_n   = state;
    rem_n     = rem;
    cnt_n     = cnt;
    sel_b_n   = sel_b;
    quarter_n = 1'b0;
    dime_n    = 1'b0;
    nickel_n  = 1'b0;
    insuff_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (inSelA || inSelB) begin
          if (inCredit >= price) begin
            state_n = DISPENSE;
            rem_n   = inCredit - price;
            cnt_n   = CNT0;
            sel_b_n = !inSelA;
          end else begin
            insuff_n = 1'b1;
          end
        end
`ifdef VEND_CANCEL_EN
        else if (inCancel && inCredit != '0) begin
          state_n = CHANGE;
          rem_n   = inCredit;
        end
`endif
      end
      DISPENSE: begin
        if (cnt == '0) state_n = CHANGE;
        else           cnt_n   = cnt - 4'd1;
      end
      CHANGE: begin
        // Greedy; a residue below 5 cents is dropped.
        if (rem >= C25) begin
          quarter_n = 1'b1;
          rem_n     = rem - C25;
        end else if (rem >= C10) begin
          dime_n = 1'b1;
          rem_n  = rem - C10;
        end else if (rem >= C5) begin
          nickel_n = 1'b1;
          rem_n    = rem - C5;
        end else begin
          state_n = CLEAR;
        end
      end
      CLEAR: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rem             <= '0;
      cnt             <= '0;
      sel_b           <= 1'b0;
      outDispenseA    <= 1'b0;
      outDispenseB    <= 1'b0;
      outRetQuarter   <= 1'b0;
      outRetDime      <= 1'b0;
      outRetNickel    <= 1'b0;
      outResetCount   <= 1'b0;
      outInsufficient <= 1'b0;
      outCoinEnable   <= 1'b1;
    end else begin
      state           <= state_n;
      rem             <= rem_n;
      cnt             <= cnt_n;
      sel_b           <= sel_b_n;
      outDispenseA    <= (state_n == DISPENSE) && !sel_b_n;
      outDispenseB    <= (state_n == DISPENSE) && sel_b_n;
      outRetQuarter   <= quarter_n;
      outRetDime      <= dime_n;
      outRetNickel    <= nickel_n;
      outResetCount   <= (state_n == CLEAR);
      outInsufficient <= insuff_n;
      outCoinEnable   <= (state_n == IDLE);
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed cases plus
// randomized transactions against a per-cycle output trace model.
module tb_vend_controller;

  localparam int W = 10;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] inCredit;
  logic         inSelA;
  logic         inSelB;
  logic         cancel;
  logic         outDispenseA, outDispenseB;
  logic         outRetQuarter, outRetDime, outRetNickel;
  logic         outResetCount, outInsufficient, outCoinEnable;
  logic [7:0]   obs;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  vend_controller dut (
    .clk             (clk),
    .reset           (reset),
    .inCredit        (inCredit),
    .inSelA          (inSelA),
    .inSelB          (inSelB),
`ifdef VEND_CANCEL_EN
    .inCancel        (cancel),
`endif
    .outDispenseA    (outDispenseA),
    .outDispenseB    (outDispenseB),
    .outRetQuarter   (outRetQuarter),
    .outRetDime      (outRetDime),
    .outRetNickel    (outRetNickel),
    .outResetCount   (outResetCount),
    .outInsufficient (outInsufficient),
    .outCoinEnable   (outCoinEnable)
  );

  // bit order: dispA dispB qtr dime nickel clear insuff coin_en
  assign obs = {outDispenseA, outDispenseB, outRetQuarter,
                outRetDime, outRetNickel, outResetCount,
                outInsufficient, outCoinEnable};

  task automatic check(input string tag, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected outputs for each cycle following the acceptance edge.
  function automatic void model(input int credit, input bit a,
                                input bit b, input bit c);
    int  rem;
    int  price;
    bit  go;
    bit  can;
    go  = 1'b0;
    rem = 0;
`ifdef VEND_CANCEL_EN
    can = c;
`else
    can = 1'b0;
    if (c) can = 1'b0;
`endif
    exp_q.delete();
    if (a || b) begin
      price = a ? 65 : 85;
      if (credit >= price) begin
        repeat (N) exp_q.push_back(a ? 8'h80 : 8'h40);
        rem = credit - price;
        go  = 1'b1;
      end else begin
        exp_q.push_back(8'h03);
      end
    end else if (can && credit != 0) begin
      rem = credit;
      go  = 1'b1;
    end
    if (go) begin
      exp_q.push_back(8'h00);
      repeat (rem / 25) exp_q.push_back(8'h20);
      rem = rem % 25;
      repeat (rem / 10) exp_q.push_back(8'h10);
      rem = rem % 10;
      repeat (rem / 5) exp_q.push_back(8'h08);
      exp_q.push_back(8'h04);
    end
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
  endfunction

  task automatic run(input int credit, input bit a, input bit b,
                     input bit c, input string tag);
    @(negedge clk);
    inCredit = W'(credit);
    inSelA   = a;
    inSelB   = b;
    cancel   = c;
    model(credit, a, b, c);
    @(posedge clk);
    #1;
    inSelA   = 1'b0;
    inSelB   = 1'b0;
    cancel   = 1'b0;
    inCredit = W'($urandom_range(0, 1023));
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), exp_q[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  cr;
    bit  a, b, c;
    reset    = 1'b1;
    inCredit = '0;
    inSelA   = 1'b0;
    inSelB   = 1'b0;
    cancel   = 1'b0;
    @(negedge clk);
    check("reset_state", 8'h01);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 8'h01);

    run(65,  1'b1, 1'b0, 1'b0, "exact_a");
    run(100, 1'b1, 1'b0, 1'b0, "change_a");
    run(50,  1'b0, 1'b1, 1'b0, "insuff_b");
    run(100, 1'b1, 1'b1, 1'b0, "both_sel");
    run(85,  1'b0, 1'b1, 1'b0, "exact_b");
    run(64,  1'b1, 1'b0, 1'b0, "below_a");
    run(69,  1'b1, 1'b0, 1'b0, "residue");
    run(1023, 1'b0, 1'b1, 1'b0, "max_credit");
    run(90,  1'b0, 1'b0, 1'b0, "no_sel");

    // Reset mid-change must abort without a counter clear.
    @(negedge clk);
    inCredit = W'(120);
    inSelB   = 1'b1;
    @(posedge clk);
    #1;
    inSelB = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("rst_disp", 8'h40);
    end
    @(negedge clk);
    check("rst_gap", 8'h00);
    @(negedge clk);
    check("rst_quarter", 8'h20);
    reset = 1'b1;
    #1;
    check("rst_async", 8'h01);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_idle", 8'h01);
    end

`ifdef VEND_CANCEL_EN
    run(40, 1'b0, 1'b0, 1'b1, "cancel");
    run(0,  1'b0, 1'b0, 1'b1, "cancel_zero");
    run(70, 1'b1, 1'b0, 1'b1, "cancel_vs_sel");
`endif

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) cr = int'($urandom_range(0, 1023));
      else                           cr = int'($urandom_range(0, 200));
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      run(cr, a, b, c, $sformatf("rand%0d_c%0d", t, cr));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
